// File: rtl/apb_master_bridge.sv
// Command/response to APB master bridge.
// One transfer in flight; a wait-state limit turns a stuck slave into an error response.
module apb_master_bridge #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              Pclk,
   input  logic              Prst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_tout,
   output logic [ADDR_W-1:0] Paddr,
   output logic              Pselx,
   output logic              Penable,
   output logic              Pwrite,
   output logic [DATA_W-1:0] Pwdata,
   input  logic              Pready,
   input  logic              Pslverr,
   input  logic [DATA_W-1:0] Prdata
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_e;

   localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              psel_q, psel_d;
   logic              pen_q, pen_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rerr_q, rerr_d;
   logic              rtout_q, rtout_d;

   logic accept, done, expire;

   assign accept = (state_q == IDLE) && cmd_ready_q && cmd_valid;
   assign done   = (state_q == ACCESS) && Pready;
   assign expire = (state_q == ACCESS) && !Pready && (cnt_q == TMAX);

   always_ff @(posedge Pclk) begin
      if (!Prst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         pen_q       <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         rerr_q      <= 1'b0;
         rtout_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         pen_q       <= pen_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         rerr_q      <= rerr_d;
         rtout_q     <= rtout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (done || expire) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_d = (state_d == IDLE);
      psel_d      = (state_d == SETUP) || (state_d == ACCESS);
      pen_d       = (state_d == ACCESS);
      rvalid_d    = (state_d == RESP);
      cnt_d       = cnt_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rdata_d     = rdata_q;
      rerr_d      = rerr_q;
      rtout_d     = rtout_q;
      if (accept) begin
         cnt_d    = '0;
         pwrite_d = cmd_write;
         paddr_d  = cmd_addr;
         pwdata_d = cmd_wdata;
      end
      if (state_q == ACCESS && !Pready) begin
         cnt_d = cnt_q + 8'd1;
      end
      // Completion wins over expiry on the final wait cycle.
      if (done) begin
         rdata_d = pwrite_q ? '0 : Prdata;
         rerr_d  = Pslverr;
         rtout_d = 1'b0;
      end else if (expire) begin
         rdata_d = '0;
         rerr_d  = 1'b1;
         rtout_d = 1'b1;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign Pselx     = psel_q;
   assign Penable   = pen_q;
   assign Pwrite    = pwrite_q;
   assign Paddr     = paddr_q;
   assign Pwdata    = pwdata_q;
   assign rsp_valid = rvalid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = rerr_q;
   assign rsp_tout  = rtout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed corner cases plus random
// transfers scored against a transaction-level timing model.
module tb_apb_master_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          Pclk = 1'b0;
   logic          Prst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err, rsp_tout;
   logic [AW-1:0] Paddr;
   logic          Pselx, Penable, Pwrite;
   logic [DW-1:0] Pwdata;
   logic          Pready, Pslverr;
   logic [DW-1:0] Prdata;

   int n_chk = 0;
   int n_err = 0;

   apb_master_bridge #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TIMEOUT(TO)
   ) dut (
      .Pclk     (Pclk),
      .Prst     (Prst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .rsp_tout (rsp_tout),
      .Paddr    (Paddr),
      .Pselx    (Pselx),
      .Penable  (Penable),
      .Pwrite   (Pwrite),
      .Pwdata   (Pwdata),
      .Pready   (Pready),
      .Pslverr  (Pslverr),
      .Prdata   (Prdata)
   );

   always #5 Pclk = ~Pclk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Pclk);
      #1;
   endtask

   task automatic noise();
      Pready  = 1'($urandom);
      Pslverr = 1'($urandom);
      Prdata  = $urandom;
   endtask

   // One transfer. w = wait states before Pready (w >= TO never completes),
   // d = cycles rsp_ready stays low. Called one cycle after an edge in IDLE.
   task automatic xfer(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int w,
                       input logic serr, input logic [DW-1:0] rd,
                       input int d);
      int            nacc;
      logic [DW-1:0] e_rd;
      logic          e_err, e_to;
      nacc  = (w < TO) ? w + 1 : TO;
      e_rd  = (w < TO && !wr) ? rd : '0;
      e_err = (w < TO) ? serr : 1'b1;
      e_to  = (w >= TO);
      check("idle_ready", cmd_ready, 1'b1);
      check("idle_rvalid", rsp_valid, 1'b0);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = wd;
      rsp_ready = 1'($urandom);
      noise();
      tick();
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      check("setup_sel", Pselx, 1'b1);
      check("setup_en", Penable, 1'b0);
      check("setup_ready", cmd_ready, 1'b0);
      check("setup_addr", Paddr, a);
      check("setup_wr", Pwrite, wr);
      check("setup_wdata", Pwdata, wd);
      noise();
      tick();
      for (int k = 0; k < nacc; k++) begin
         check("acc_sel", Pselx, 1'b1);
         check("acc_en", Penable, 1'b1);
         check("acc_addr", Paddr, a);
         check("acc_wr", Pwrite, wr);
         check("acc_wdata", Pwdata, wd);
         check("acc_rvalid", rsp_valid, 1'b0);
         Pready  = (k == w);
         Pslverr = (k == w) ? serr : 1'($urandom);
         Prdata  = (k == w) ? rd : $urandom;
         tick();
      end
      for (int i = 0; i <= d; i++) begin
         check("rsp_valid", rsp_valid, 1'b1);
         check("rsp_rdata", rsp_rdata, e_rd);
         check("rsp_err", rsp_err, e_err);
         check("rsp_tout", rsp_tout, e_to);
         check("rsp_cmdrdy", cmd_ready, 1'b0);
         check("rsp_sel", Pselx, 1'b0);
         check("rsp_en", Penable, 1'b0);
         rsp_ready = (i == d);
         noise();
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'($urandom);
      check("post_rvalid", rsp_valid, 1'b0);
      check("post_ready", cmd_ready, 1'b1);
      check("post_sel", Pselx, 1'b0);
      check("post_addr", Paddr, a);
      check("post_wr", Pwrite, wr);
      check("post_wdata", Pwdata, wd);
   endtask

   // Reset hit during SETUP (0), ACCESS (1) or RESP (2).
   task automatic reset_mid(input int stage);
      check("rm_idle", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      Pready    = 1'b0;
      rsp_ready = 1'b0;
      tick();
      cmd_valid = 1'b0;
      if (stage >= 1) tick();
      if (stage >= 2) begin
         Pready = 1'b1;
         Prdata = $urandom;
         tick();
         Pready = 1'b0;
         check("rm_resp", rsp_valid, 1'b1);
      end
      Prst = 1'b0;
      tick();
      check("rm_sel", Pselx, 1'b0);
      check("rm_en", Penable, 1'b0);
      check("rm_rvalid", rsp_valid, 1'b0);
      check("rm_addr", Paddr, '0);
      check("rm_err", rsp_err, 1'b0);
      check("rm_rdata", rsp_rdata, '0);
      Prst = 1'b1;
      tick();
      check("rm_rdy", cmd_ready, 1'b1);
      check("rm_rv2", rsp_valid, 1'b0);
   endtask

   initial begin
      Prst      = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      Pready    = 1'b0;
      Pslverr   = 1'b0;
      Prdata    = '0;
      tick();
      tick();
      check("rst_sel", Pselx, 1'b0);
      check("rst_en", Penable, 1'b0);
      check("rst_addr", Paddr, '0);
      check("rst_wr", Pwrite, 1'b0);
      check("rst_wdata", Pwdata, '0);
      check("rst_rvalid", rsp_valid, 1'b0);
      check("rst_rdata", rsp_rdata, '0);
      check("rst_err", rsp_err, 1'b0);
      check("rst_tout", rsp_tout, 1'b0);
      Prst = 1'b1;
      tick();
      check("rst_ready", cmd_ready, 1'b1);

      xfer(1'b1, 32'hA5A5_0001, 32'h5, 0, 1'b0, 32'hDEAD_BEEF, 0);
      xfer(1'b0, 32'h5, 32'h0, 3, 1'b0, 32'hA5A5_0001, 0);
      xfer(1'b0, 32'h40, 32'h0, TO, 1'b0, 32'h1234_5678, 0);
      xfer(1'b0, 32'h44, 32'h0, TO - 1, 1'b0, 32'h1234_5678, 0);
      xfer(1'b1, 32'h48, 32'h77, TO + 3, 1'b0, 32'h0, 1);
      xfer(1'b0, 32'h4C, 32'h0, 1, 1'b1, 32'hCAFE_F00D, 0);
      xfer(1'b0, 32'h50, 32'h0, 2, 1'b0, 32'h0BAD_CAFE, 5);

      for (int s = 0; s < 3; s++) begin
         reset_mid(s);
         xfer(1'b0, 32'h60, 32'h0, 0, 1'b0, 32'h1357_9BDF, 0);
      end

      for (int t = 0; t < 150; t++) begin
         logic          wr, se;
         logic [AW-1:0] a;
         logic [DW-1:0] wd, rd;
         int            w, d;
         wr = 1'($urandom);
         se = ($urandom_range(0, 3) == 0);
         a  = $urandom;
         wd = $urandom;
         rd = $urandom;
         w  = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2)
                                          : $urandom_range(0, 4);
         d  = $urandom_range(0, 3);
         xfer(wr, a, wd, w, se, rd, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
